hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage MIPS-style core. It watches the ID and EX stages plus the data-memory handshake. It drives the enable, flush and bubble controls of the PC, IF/ID and ID/EX stage registers, covering:
- load-use stalls
- taken-branch flushes
- multi-cycle memory waits, with a timeout watchdog that latches a sticky fault.

---
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller signal bundle (master = pipeline side, slave = controller)
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pipe_hold;
    logic        mem_fault;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken,
               dmem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
               mem_fault, stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken,
               dmem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
               mem_fault, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch-flush / memory-wait hazard controller with timeout fault
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FAULT    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_fault_q, mem_fault_d;

    logic       lu;
    logic       run_eval;
    logic       pc_write_c;
    logic       ifid_write_c;
    logic       ifid_flush_c;
    logic       idex_bubble_c;
    logic       pipe_hold_c;

    assign lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_fault_d   = mem_fault_q;
        run_eval      = 1'b0;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        pipe_hold_c   = 1'b0;

        if (reset) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
        end else begin
            case (state_q)
                S_RUN: run_eval = 1'b1;
                S_MEM_WAIT: begin
                    if (hz.dmem_ready) begin
                        // Held branch / load-use is serviced in the completion cycle
                        run_eval   = 1'b1;
                        state_d    = S_RUN;
                        wait_cnt_d = 8'd0;
                    end else begin
                        pc_write_c   = 1'b0;
                        ifid_write_c = 1'b0;
                        pipe_hold_c  = 1'b1;
                        wait_cnt_d   = wait_cnt_q + 8'd1;
                        if (wait_cnt_d == TIMEOUT) begin
                            state_d     = S_FAULT;
                            mem_fault_d = 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    pipe_hold_c  = 1'b1;
                end
                default: state_d = S_RUN;
            endcase

            if (run_eval) begin
                if (hz.dmem_req && !hz.dmem_ready) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    pipe_hold_c  = 1'b1;
                    state_d      = S_MEM_WAIT;
                    wait_cnt_d   = 8'd1;
                end else if (hz.ex_branch_taken) begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (lu) begin
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_bubble_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= 8'd0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign hz.pc_write    = pc_write_c;
    assign hz.ifid_write  = ifid_write_c;
    assign hz.ifid_flush  = ifid_flush_c;
    assign hz.idex_bubble = idex_bubble_c;
    assign hz.pipe_hold   = pipe_hold_c;
    assign hz.mem_fault   = mem_fault_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Both counters saturate rather than wrap
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!reset && (state_q != S_FAULT) && !pc_write_c && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
        if (!reset && ifid_flush_c && (flush_count_q != 16'hFFFF))
            flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign hz.stall_count = stall_count_q;
    assign hz.flush_count = flush_count_q;
`else
    assign hz.stall_count = 16'd0;
    assign hz.flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4)
module tb_hazard_ctrl;

`ifdef HAZARD_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
    logic [4:0] ctl;
    assign ctl = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.pipe_hold};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mr, input logic [4:0] exrt, input logic br,
                         input logic req, input logic rdy);
        hz.id_rs           = rs;
        hz.id_rt           = rt;
        hz.id_uses_rt      = uses;
        hz.ex_mem_read     = mr;
        hz.ex_rt           = exrt;
        hz.ex_branch_taken = br;
        hz.dmem_req        = req;
        hz.dmem_ready      = rdy;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_ctl", 16'(ctl), 16'b00110);
        chk("reset_fault", 16'(hz.mem_fault), 16'd0);
        cyc();
        cyc();
        chk("reset_stall_cnt", hz.stall_count, 16'd0);
        chk("reset_flush_cnt", hz.flush_count, 16'd0);
        reset = 1'b0;

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("run_default", 16'(ctl), 16'b11000);

        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_rs", 16'(ctl), 16'b00010);
        cyc();
        drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_cleared", 16'(ctl), 16'b11000);

        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_rt_zero", 16'(ctl), 16'b11000);
        drive(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lu_rt_unused", 16'(ctl), 16'b11000);
        drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lu_rt_used", 16'(ctl), 16'b00010);
        cyc();
        chk("stall_cnt_lu", hz.stall_count, 16'(2 * STATS));
        chk("flush_cnt_lu", hz.flush_count, 16'd0);

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("branch_over_lu", 16'(ctl), 16'b11110);
        cyc();
        chk("flush_cnt_br", hz.flush_count, 16'(STATS));
        chk("stall_cnt_br", hz.stall_count, 16'd0);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw_c1", 16'(ctl), 16'b00001);
        cyc();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw_c2", 16'(ctl), 16'b00001);
        cyc();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw_c3", 16'(ctl), 16'b00001);
        cyc();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("mw_ready", 16'(ctl), 16'b11000);
        cyc();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("mw_first_ready_nohold", 16'(ctl), 16'b11000);
        chk("mw_no_fault", 16'(hz.mem_fault), 16'd0);
        chk("stall_cnt_mw", hz.stall_count, 16'(3 * STATS));
        cyc();

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("hb_c1_noflush", 16'(ctl), 16'b00001);
        cyc();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("hb_c2_noflush", 16'(ctl), 16'b00001);
        cyc();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        chk("hb_ready_flush", 16'(ctl), 16'b11110);
        cyc();

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("to_c1", 16'(ctl), 16'b00001);
        cyc();
        chk("to_edge1", 16'(hz.mem_fault), 16'd0);
        cyc();
        cyc();
        chk("to_edge3", 16'(hz.mem_fault), 16'd0);
        cyc();
        chk("to_edge4_fault", 16'(hz.mem_fault), 16'd1);
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
        chk("fault_frozen", 16'(ctl), 16'b00001);
        cyc();
        chk("fault_sticky", 16'(hz.mem_fault), 16'd1);
        chk("fault_frozen2", 16'(ctl), 16'b00001);
        cyc();
        chk("stall_cnt_fault", hz.stall_count, 16'(9 * STATS));
        chk("flush_cnt_fault", hz.flush_count, 16'(2 * STATS));

        #2;
        reset = 1'b1;
        #1;
        chk("rst_in_fault_flag", 16'(hz.mem_fault), 16'd0);
        chk("rst_in_fault_ctl", 16'(ctl), 16'b00110);
        chk("rst_in_fault_stall", hz.stall_count, 16'd0);
        cyc();
        reset = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_fault_run", 16'(ctl), 16'b11000);
        cyc();

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw_before_rst", 16'(ctl), 16'b00001);
        reset = 1'b1;
        #1;
        chk("rst_in_mw_ctl", 16'(ctl), 16'b00110);
        cyc();
        reset = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_mw_run", 16'(ctl), 16'b11000);
        chk("post_rst_mw_fault", 16'(hz.mem_fault), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
